// File: rtl/ola_capture_pkg.sv
// Shared definitions for the logic-analyser capture sequencer.
package ola_capture_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } capture_state_t;

endpackage

// File: rtl/ola_capture_control.sv
// Capture sequencer: arms on request, streams samples into a ring buffer and,
// after a trigger, stops once the external countdown has consumed the post-trigger samples.
module ola_capture_control
  import ola_capture_pkg::*;
#(
  parameter int data_width  = 32,
  parameter int addr_width  = 10,
  parameter int count_width = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_arm,
  input  logic                   in_abort,
  input  logic                   in_valid,
  input  logic [data_width-1:0]  in_data,
  input  logic                   in_trigger,
  input  logic [count_width-1:0] in_post_count,
  output logic                   cd_valid,
  output logic                   cd_run,
  output logic                   cd_setup,
  output logic [count_width-1:0] cd_value,
  input  logic                   cd_expired,
  output logic                   out_mem_write,
  output logic [addr_width-1:0]  out_mem_addr,
  output logic [data_width-1:0]  out_mem_data,
  output logic [addr_width-1:0]  out_trigger_addr,
  output logic [addr_width-1:0]  out_end_addr,
  output logic                   out_wrapped,
  output logic                   out_busy,
  output logic                   out_done
);

  capture_state_t        state;
  logic [addr_width-1:0] wr_ptr;
  logic                  post_seen;
  logic                  arm_load;

  assign arm_load = ((state == IDLE) || (state == DONE)) && in_arm && !in_abort;

  // The countdown is loaded on arm but only decrements while TRIGGERED.
  assign cd_valid = arm_load | in_valid;
  assign cd_run   = arm_load | (state == TRIGGERED);
  assign cd_setup = arm_load;
  assign cd_value = in_post_count;

  assign out_busy = (state == ARMED) || (state == TRIGGERED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      post_seen        <= 1'b0;
      out_mem_write    <= 1'b0;
      out_mem_addr     <= '0;
      out_mem_data     <= '0;
      out_trigger_addr <= '0;
      out_end_addr     <= '0;
      out_wrapped      <= 1'b0;
      out_done         <= 1'b0;
    end else begin
      out_mem_write <= 1'b0;
      out_done      <= 1'b0;
      if (in_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (in_arm) begin
              state       <= ARMED;
              wr_ptr      <= '0;
              out_wrapped <= 1'b0;
              post_seen   <= 1'b0;
            end
          end
          ARMED: begin
            if (in_valid) begin
              out_mem_write <= 1'b1;
              out_mem_addr  <= wr_ptr;
              out_mem_data  <= in_data;
              out_end_addr  <= wr_ptr;
              wr_ptr        <= wr_ptr + 1'b1;
              if (wr_ptr == '1) out_wrapped <= 1'b1;
              if (in_trigger) begin
                out_trigger_addr <= wr_ptr;
                if (in_post_count == '0) begin
                  state    <= DONE;
                  out_done <= 1'b1;
                end else begin
                  state <= TRIGGERED;
                end
              end
            end
          end
          TRIGGERED: begin
            // Expired is stale from the arm load until a post sample has been taken.
            if (cd_expired && post_seen) begin
              state    <= DONE;
              out_done <= 1'b1;
            end else if (in_valid) begin
              out_mem_write <= 1'b1;
              out_mem_addr  <= wr_ptr;
              out_mem_data  <= in_data;
              out_end_addr  <= wr_ptr;
              wr_ptr        <= wr_ptr + 1'b1;
              post_seen     <= 1'b1;
              if (wr_ptr == '1) out_wrapped <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ola_capture_control.sv
// Self-checking bench for ola_capture_control with a behavioural countdown neighbour.
module tb_ola_capture_control;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int CW    = 32;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_arm = 1'b0, in_abort = 1'b0, in_valid = 1'b0, in_trigger = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_post_count = '0;
  logic          cd_valid, cd_run, cd_setup, cd_expired;
  logic [CW-1:0] cd_value;
  logic          out_mem_write, out_wrapped, out_busy, out_done;
  logic [AW-1:0] out_mem_addr, out_trigger_addr, out_end_addr;
  logic [DW-1:0] out_mem_data;

  int tests = 0;
  int fails = 0;

  ola_capture_control #(.data_width(DW), .addr_width(AW), .count_width(CW)) dut (
    .clock(clock), .reset_n(reset_n), .in_arm(in_arm), .in_abort(in_abort),
    .in_valid(in_valid), .in_data(in_data), .in_trigger(in_trigger),
    .in_post_count(in_post_count), .cd_valid(cd_valid), .cd_run(cd_run),
    .cd_setup(cd_setup), .cd_value(cd_value), .cd_expired(cd_expired),
    .out_mem_write(out_mem_write), .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .out_trigger_addr(out_trigger_addr), .out_end_addr(out_end_addr),
    .out_wrapped(out_wrapped), .out_busy(out_busy), .out_done(out_done)
  );

  always #5 clock = ~clock;

  // Neighbouring countdown: loads on setup, decrements on valid&run, expired at zero.
  logic [CW-1:0] cd_cnt;
  assign cd_expired = (cd_cnt == '0);
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cd_cnt <= '0;
    else if (cd_setup) cd_cnt <= cd_value;
    else if (cd_valid && cd_run && cd_cnt != '0) cd_cnt <= cd_cnt - 1;
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wq[$];
  int  done_total = 0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (out_mem_write) wq.push_back({out_mem_addr, out_mem_data});
      if (out_done) done_total++;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Arms, streams pre+1+post samples (plus extras that must be dropped) and checks
  // the captured stream against a plain list model of the ring buffer.
  task automatic run_capture(input int pre, input int post, input int gap_fixed,
                             input int gap_rand, input string name);
    logic [DW-1:0] samp[$];
    int            base, dbase, total, n, g;
    wr_t           got, exp_w;
    logic [AW-1:0] exp_a;
    base  = wq.size();
    dbase = done_total;
    in_post_count = CW'(post);
    in_arm = 1'b1;
    cyc();
    in_arm = 1'b0;
    total = pre + 1 + post;
    n = total + 1 + int'($urandom_range(3));
    for (int i = 0; i < n; i++) begin
      g = gap_fixed + ((gap_rand > 0) ? int'($urandom_range(gap_rand)) : 0);
      for (int k = 0; k < g; k++) begin
        in_valid   = 1'b0;
        in_trigger = 1'($urandom_range(1));
        in_data    = $urandom;
        cyc();
      end
      in_valid   = 1'b1;
      in_data    = $urandom;
      in_trigger = (i == pre);
      samp.push_back(in_data);
      cyc();
    end
    in_valid = 1'b0;
    in_trigger = 1'b0;
    for (int w = 0; w < 40 && done_total == dbase; w++) cyc();
    cyc();
    cyc();
    tests++;
    if (done_total - dbase !== 1) begin
      fails++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_total - dbase);
    end
    tests++;
    if (out_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_after: got %b expected 0", name, out_busy);
    end
    tests++;
    if (wq.size() - base !== total) begin
      fails++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wq.size() - base, total);
    end
    for (int i = 0; i < total && base + i < wq.size(); i++) begin
      got   = wq[base + i];
      exp_w = {AW'(i % DEPTH), samp[i]};
      tests++;
      if (got !== exp_w) begin
        fails++;
        $display("FAIL %s write[%0d]: got a=%0d d=%h expected a=%0d d=%h",
                 name, i, got.a, got.d, exp_w.a, exp_w.d);
      end
    end
    exp_a = AW'(pre % DEPTH);
    tests++;
    if (out_trigger_addr !== exp_a) begin
      fails++;
      $display("FAIL %s trigger_addr: got %0d expected %0d", name, out_trigger_addr, exp_a);
    end
    exp_a = AW'((pre + post) % DEPTH);
    tests++;
    if (out_end_addr !== exp_a) begin
      fails++;
      $display("FAIL %s end_addr: got %0d expected %0d", name, out_end_addr, exp_a);
    end
    tests++;
    if (out_wrapped !== (total >= DEPTH)) begin
      fails++;
      $display("FAIL %s wrapped: got %b expected %b", name, out_wrapped, total >= DEPTH);
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({cd_valid, cd_run, cd_setup, cd_value, out_mem_write, out_mem_addr, out_mem_data,
         out_trigger_addr, out_end_addr, out_wrapped, out_busy, out_done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b wr=%b addr=%0d expected all zero",
               out_busy, out_done, out_mem_write, out_mem_addr);
    end
  endtask

  task automatic test_directed();
    run_capture(5, 3, 0, 0, "basic");
    run_capture(5, 3, 2, 0, "gaps");
    run_capture(2, 0, 0, 0, "post_zero");
    run_capture(20, 2, 0, 0, "wrap");
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++)
      run_capture(int'($urandom_range(25)), int'($urandom_range(20)), 0,
                  int'($urandom_range(2)), "random");
  endtask

  task automatic send_sample(input logic trig);
    in_valid = 1'b1; in_trigger = trig; in_data = $urandom;
    cyc();
    in_valid = 1'b0; in_trigger = 1'b0;
  endtask

  task automatic test_abort_rearm();
    int base, dbase, base2;
    base = wq.size(); dbase = done_total;
    in_post_count = 5; in_arm = 1'b1; cyc(); in_arm = 1'b0;
    for (int i = 0; i < 3; i++) send_sample(1'b0);
    send_sample(1'b1);
    send_sample(1'b0);
    in_abort = 1'b1; in_valid = 1'b1; in_data = $urandom;
    cyc();
    in_abort = 1'b0;
    tests++;
    if (out_busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_busy: got %b expected 0", out_busy);
    end
    repeat (4) cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    tests++;
    if (wq.size() - base !== 5) begin
      fails++;
      $display("FAIL abort_writes: got %0d expected 5", wq.size() - base);
    end
    tests++;
    if (done_total !== dbase) begin
      fails++;
      $display("FAIL abort_done: got %0d pulses expected 0", done_total - dbase);
    end
    in_post_count = 7; in_arm = 1'b1;
    #1;
    tests++;
    if ({cd_setup, cd_valid, cd_run, cd_value} !== {3'b111, CW'(7)}) begin
      fails++;
      $display("FAIL rearm_cd: got setup=%b valid=%b run=%b value=%0d expected 1 1 1 7",
               cd_setup, cd_valid, cd_run, cd_value);
    end
    cyc();
    in_arm = 1'b0;
    base2 = wq.size();
    send_sample(1'b0);
    cyc();
    tests++;
    if (wq.size() <= base2 || wq[base2].a !== '0) begin
      fails++;
      $display("FAIL rearm_ptr: got %0d writes addr=%0d expected addr 0",
               wq.size() - base2, (wq.size() > base2) ? wq[base2].a : 0);
    end
    in_abort = 1'b1; cyc(); in_abort = 1'b0;
  endtask

  task automatic test_arm_abort_same();
    in_arm = 1'b1; in_abort = 1'b1;
    #1;
    tests++;
    if (cd_setup !== 1'b0) begin
      fails++;
      $display("FAIL arm_abort_setup: got %b expected 0", cd_setup);
    end
    cyc();
    in_arm = 1'b0; in_abort = 1'b0;
    tests++;
    if (out_busy !== 1'b0) begin
      fails++;
      $display("FAIL arm_abort_busy: got %b expected 0", out_busy);
    end
  endtask

  task automatic test_trigger_no_valid();
    int base, dbase;
    in_post_count = 2; in_arm = 1'b1; cyc(); in_arm = 1'b0;
    base = wq.size(); dbase = done_total;
    in_trigger = 1'b1;
    repeat (3) cyc();
    in_trigger = 1'b0;
    for (int i = 0; i < 4; i++) send_sample(1'b0);
    cyc(); cyc();
    tests++;
    if (out_busy !== 1'b1 || done_total !== dbase) begin
      fails++;
      $display("FAIL trig_no_valid: got busy=%b done=%0d expected busy=1 done=0",
               out_busy, done_total - dbase);
    end
    tests++;
    if (wq.size() - base !== 4) begin
      fails++;
      $display("FAIL trig_no_valid_writes: got %0d expected 4", wq.size() - base);
    end
    in_abort = 1'b1; cyc(); in_abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_post_count = 10; in_arm = 1'b1; cyc(); in_arm = 1'b0;
    send_sample(1'b0); send_sample(1'b0); send_sample(1'b1);
    send_sample(1'b0); send_sample(1'b0);
    in_post_count = '0;
    #2 reset_n = 1'b0;
    #1;
    test_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    tests++;
    if (out_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_busy: got %b expected 0", out_busy);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    test_reset();
    test_directed();
    test_abort_rearm();
    test_arm_abort_same();
    test_trigger_no_valid();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
